serial_add_sequencer: RTL
=========================

Name: serial_add_sequencer

Overview:
Bit-serial multi-bit adder front end that sits directly upstream of the one-bit full adder. It accepts WIDTH-bit operands through a valid/ready handshake and feeds the full adder one bit pair per step, LSB first, threading the carry between steps. It collects the returned sum/carry bits into a WIDTH-bit result plus carry-out and presents them on a valid/ready output.

Parameters:
WIDTH, 8, operand and result width in bits; legal range >= 1.
FA_LAT, 1, full adder latency in clk cycles from fa_a/fa_b/fa_cin to a valid fa_s; legal values 0 or 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
resetn  input  1  synchronous, active-low reset.
in_valid  input  1  operand request valid.
in_ready  output  1  block can accept operands; high only in IDLE.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_cin  input  1  carry-in for bit 0.
fa_a  output  1  bit of A driven to the full adder.
fa_b  output  1  bit of B driven to the full adder.
fa_cin  output  1  running carry driven to the full adder.
fa_s  input  2  full adder result: [0] is the sum bit, [1] is the carry bit.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out_sum  output  WIDTH  (in_a + in_b + in_cin) mod 2^WIDTH.
out_cout  output  1  bit WIDTH of in_a + in_b + in_cin.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (resetn low at a rising edge): state goes to IDLE; shift registers, carry, and bit counter clear. out_valid, out_sum, out_cout, fa_a, fa_b, fa_cin, and busy all go to 0. in_ready is 1 from the first edge on which reset is sampled.
- Reset mid-operation aborts the transaction. No out_valid is produced and the partial result is discarded.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_a and in_b into shift registers, load carry with in_cin, set bit index to 0, and go to ISSUE.
  - ISSUE: drive fa_a=A_sh[0], fa_b=B_sh[0], fa_cin=carry.
    - If FA_LAT=0: sample fa_s at this edge.
    - If FA_LAT=1: go to WAIT, holding the fa_* outputs stable.
  - WAIT (FA_LAT=1 only): fa_* held. Sample fa_s at this edge.
  - Sample action: shift fa_s[0] into result bit [index], set carry=fa_s[1], shift A_sh and B_sh right by one, and index++. If index was WIDTH-1, go to DONE; otherwise go to ISSUE.
  - DONE: out_valid=1, out_sum and out_cout=final carry held stable. On out_ready go to IDLE and clear out_valid at that edge.
- fa_a, fa_b, and fa_cin are 0 in IDLE and DONE.
- Latency: after an input handshake at edge E0, out_valid rises after edge E0 + WIDTH*(FA_LAT+1).
  - WIDTH=8, FA_LAT=1: 16 cycles.
  - FA_LAT=0: 8 cycles.
- Throughput: one transaction in flight. in_valid is ignored outside IDLE, and operands are not captured while busy.
- Back-pressure: out_valid stays high and out_sum/out_cout stay constant until out_ready. The earliest next accept is the cycle after the output handshake, since in_ready is combinational from state==IDLE.
- out_valid and out_ready both high on the DONE entry cycle: the handshake completes in that cycle.
- Arithmetic: fully unsigned. The carry out of bit WIDTH-1 goes to out_cout; there is no overflow flag.
- The bit counter is ceil(log2(WIDTH)) bits wide, or 1 bit when WIDTH=1. WIDTH=1 performs a single step.

Test Plan:
1. WIDTH=8, FA_LAT=1; in_a=8'h00, in_b=8'h00, in_cin=0 -> out_sum=8'h00, out_cout=0. out_valid rises exactly 16 cycles after accept. fa_a/fa_b/fa_cin=0 at every step.
2. in_a=8'hFF, in_b=8'h01, in_cin=0 -> out_sum=8'h00, out_cout=1. fa_cin=1 for bits 1..7, checked per ISSUE cycle.
3. in_a=8'hA5, in_b=8'h5A, in_cin=1 -> out_sum=8'h00, out_cout=1. Per-bit trace checks that fa_a in step i equals 8'hA5[i].
4. Back-pressure on in_a=8'h12, in_b=8'h34: hold out_ready=0 for 5 cycles after out_valid -> out_valid=1 and out_sum=8'h46 stable throughout. in_ready=0 throughout. A second in_valid pulse during this window is not captured.
5. Reset after 3 sampled bits of 8'hF0+8'h0F -> out_valid never asserts, and in_ready=1 after the reset edge. The next transaction 8'h7F+8'h01 with cin=0 returns 8'h80, out_cout=0.
6. FA_LAT=0 instance: back-to-back 8'h80+8'h80 then 8'h01+8'h02 with out_ready tied 1 -> results 8'h00/cout=1 then 8'h03/cout=0. Each arrives 8 cycles after its accept, and the second is accepted one cycle after the first output handshake.

Source files
------------

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder front end: streams WIDTH-bit operands LSB first through an
// external one-bit full adder and reassembles the sum and carry-out.
module serial_add_sequencer #(
    parameter int WIDTH  = 8,
    parameter int FA_LAT = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic [1:0]       fa_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic             carry;
    logic [CW-1:0]    idx;
    logic             sample;
    logic             last;

    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        in_ready  = 1'b0;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_cin    = 1'b0;
        last      = (idx == CW'(WIDTH - 1));
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                fa_a   = a_sh[0];
                fa_b   = b_sh[0];
                fa_cin = carry;
                // Combinational adder answers in the same cycle; otherwise wait one.
                if (FA_LAT == 0) begin
                    sample    = 1'b1;
                    state_nxt = last ? DONE : ISSUE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                fa_a      = a_sh[0];
                fa_b      = b_sh[0];
                fa_cin    = carry;
                sample    = 1'b1;
                state_nxt = last ? DONE : ISSUE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                a_sh  <= in_a;
                b_sh  <= in_b;
                carry <= in_cin;
                idx   <= '0;
            end
            if (sample) begin
                res[idx] <= fa_s[0];
                carry    <= fa_s[1];
                a_sh     <= a_sh >> 1;
                b_sh     <= b_sh >> 1;
                idx      <= idx + CW'(1);
            end
        end
    end

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_sum   = res;
    assign out_cout  = carry;

endmodule
